count_seeker: RTL and testbench
===============================

// Module: count_seeker
// PURPOSE
//  Drives the enable/direction interface of the up/down counter so that it
//  reaches a requested target value by the shortest wrap-around path. The
//  block keeps a mirror of the counter value and reports completion with a
//  ready/start/done handshake. It sits between control logic and the counter
//  block; both blocks share clk and rst.
// PARAMETERS
//  WIDTH  8  counter width; must match the driven counter
//  GAP    0  idle cycles between successive steps (0 = one step every cycle)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request a move; accepted only when ready=1
//  abort      in   1      stop an active move early
//  target     in   WIDTH  destination value, sampled when start is accepted
//  ready      out  1      1 in IDLE only
//  busy       out  1      1 in RUN
//  done       out  1      one-cycle pulse when a move ends
//  aborted    out  1      one-cycle pulse with done when the move was aborted
//  enable     out  1      to counter enable; 1 = counter steps this edge
//  direction  out  1      to counter direction; 1 = up, 0 = down
//  position   out  WIDTH  mirror of the counter value
// BEHAVIOUR
//  - Reset: state=IDLE, ready=1, busy=0, done=0, aborted=0, enable=0,
//    direction=1, position=0. rst overrides start and abort in the same cycle.
//    rst during RUN abandons the move; no done pulse is produced.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, start=1: latch target. diff = (target - position) mod 2^WIDTH.
//    diff==0 -> go to DONE; no enable pulses are generated.
//    diff<=2^(WIDTH-1) -> direction=1, steps=diff.
//    Otherwise direction=0, steps=2^WIDTH-diff.
//    A tie at exactly half the range moves up. Then go to RUN.
//  - RUN: enable=1 in the first RUN cycle, then once every GAP+1 cycles.
//    - At each edge where enable=1, position updates by +/-1 mod 2^WIDTH.
//      This is the same edge at which the counter steps, so the two stay
//      in lockstep.
//    - direction is constant for the whole RUN.
//    - After the final step edge: enable=0 and the state is DONE.
//    - start is ignored while in RUN.
//  - abort=1 sampled at an edge in RUN: a step taken at that edge still
//    counts. From that edge onward enable=0 and the state is DONE with
//    aborted=1. abort has no effect in IDLE or DONE.
//  - DONE lasts one cycle: done=1, ready=0, busy=0, then the state is IDLE.
//  - Latency: accepted start at edge E0 -> first enable in the cycle after
//    E0 -> done rises 1 cycle after the last step edge. Total time is
//    steps*(GAP+1)-GAP cycles of RUN plus 1 cycle of DONE.
//  - enable is 0 whenever the state is not RUN. position changes only on
//    step edges.
// TESTING
//  1. rst, then start with target=5, GAP=0 -> enable=1 for 5 cycles with
//     direction=1; position goes 1..5; done 1 cycle later; counter=5.
//  2. From 5, target=250 -> direction=0, 11 steps, position wraps
//     4..0,255..250; done asserted; the counter model matches at every edge.
//  3. target equal to position -> enable never asserts; done 1 cycle after
//     start is accepted.
//  4. From 0, target=128 (tie case) -> direction=1, 128 steps, position=128.
//  5. GAP=2, from 0, target=3 -> enable high every 3rd cycle, 7 RUN cycles,
//     position=3. start pulses during busy are ignored.
//  6. target=10, abort after 3 steps -> done and aborted pulse together,
//     position=3. A rst mid-run gives reset values on the next cycle with
//     no done pulse.

Source files
------------

// File: rtl/count_seeker.sv
// Steers an up/down counter to a requested target along the shorter wrap-around path,
// keeping a local mirror of the counter value and signalling completion via ready/done.
module count_seeker #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             enable,
  output logic             direction,
  output logic [WIDTH-1:0] position
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int               GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP);

  state_t           state_q;
  logic [WIDTH-1:0] position_q;
  logic [WIDTH-1:0] remain_q;
  logic [GW-1:0]    gap_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             enable_q;
  logic             direction_q;

  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] steps_d;
  logic             up_d;
  logic             last_step_d;

  // A distance of exactly half the range counts as "up" so ties resolve upward.
  always_comb begin
    diff_d      = target - position_q;
    up_d        = (diff_d <= HALF);
    steps_d     = up_d ? diff_d : ({WIDTH{1'b0}} - diff_d);
    last_step_d = enable_q && (remain_q == ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      position_q  <= '0;
      remain_q    <= '0;
      gap_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      enable_q    <= 1'b0;
      direction_q <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      // The mirror steps on exactly the edges where the counter sees enable.
      if (enable_q) begin
        position_q <= direction_q ? (position_q + ONE) : (position_q - ONE);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            ready_q <= 1'b0;
            if (diff_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= RUN;
              busy_q      <= 1'b1;
              enable_q    <= 1'b1;
              direction_q <= up_d;
              remain_q    <= steps_d;
            end
          end
        end
        RUN: begin
          if (enable_q) begin
            remain_q <= remain_q - ONE;
          end
          if (abort || last_step_d) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            enable_q  <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort;
          end else if (enable_q) begin
            if (GAP != 0) begin
              enable_q <= 1'b0;
              gap_q    <= GAP_LOAD;
            end
          end else if (gap_q == GW'(1)) begin
            enable_q <= 1'b1;
            gap_q    <= '0;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign enable    = enable_q;
  assign direction = direction_q;
  assign position  = position_q;

endmodule

// File: tb/tb_count_seeker.sv
// Bench for count_seeker: two instances (GAP=0 and GAP=2), a counter model driven by
// enable/direction, and a scoreboard of expected move results popped on each done pulse.
module tb_count_seeker;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s     [N];
  logic       abort_s     [N];
  logic [7:0] target_s    [N];
  logic       ready_s     [N];
  logic       busy_s      [N];
  logic       done_s      [N];
  logic       aborted_s   [N];
  logic       enable_s    [N];
  logic       direction_s [N];
  logic [7:0] pos_s       [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    count_seeker #(.WIDTH(8), .GAP(gi * 2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[gi]),
      .abort     (abort_s[gi]),
      .target    (target_s[gi]),
      .ready     (ready_s[gi]),
      .busy      (busy_s[gi]),
      .done      (done_s[gi]),
      .aborted   (aborted_s[gi]),
      .enable    (enable_s[gi]),
      .direction (direction_s[gi]),
      .position  (pos_s[gi])
    );
  end

  typedef struct {
    int inst;
    int pos;
    int abrt;
    int t0;
    int cyc;
    int steps;
    int dir;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_on   = 1'b0;
  int   model    [N];
  int   en_cnt   [N];
  int   dir_err  [N];
  bit   post_done[N];
  int   cur_pos  [N];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Counter model plus per-cycle invariants; scoreboard entries are retired on done.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (mon_on) begin
        check_eq("lockstep", pos_s[i], model[i]);
        if (enable_s[i] && !busy_s[i]) check_eq("enable_outside_run", 1, 0);
        if (aborted_s[i] && !done_s[i]) check_eq("aborted_without_done", 1, 0);
        if (post_done[i]) begin
          check_eq("ready_after_done", ready_s[i], 1);
          check_eq("done_one_cycle", done_s[i], 0);
        end
        post_done[i] = 1'b0;
        if (enable_s[i]) begin
          en_cnt[i]++;
          if (sb.size() > 0 && int'(direction_s[i]) != sb[0].dir) dir_err[i]++;
        end
        if (done_s[i]) begin
          if (sb.size() == 0 || sb[0].inst != i) begin
            check_eq("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check_eq("final_position", pos_s[i], e.pos);
            check_eq("aborted_flag", aborted_s[i], e.abrt);
            check_eq("move_cycles", cyc - e.t0, e.cyc);
            check_eq("step_count", en_cnt[i], e.steps);
            check_eq("direction_constant", dir_err[i], 0);
            $display("move dut%0d: pos=%0d steps=%0d aborted=%0d cycles=%0d",
                     i, pos_s[i], en_cnt[i], aborted_s[i], cyc - e.t0);
          end
          en_cnt[i]    = 0;
          dir_err[i]   = 0;
          post_done[i] = 1'b1;
        end
      end
      if (rst) begin
        model[i]   = 0;
        en_cnt[i]  = 0;
        dir_err[i] = 0;
      end else if (enable_s[i]) begin
        model[i] = (model[i] + (direction_s[i] ? 1 : 255)) & 255;
      end
    end
  end

  task automatic move(input int i, input int tgt, input int abort_at);
    exp_t e;
    int   diff;
    int   steps;
    int   g;
    g    = i * 2;
    diff = (tgt - cur_pos[i]) & 255;
    if (diff == 0) begin
      steps = 0;
      e.dir = -1;
    end else if (diff <= 128) begin
      steps = diff;
      e.dir = 1;
    end else begin
      steps = 256 - diff;
      e.dir = 0;
    end
    e.abrt = (abort_at > 0 && abort_at <= steps) ? 1 : 0;
    if (e.abrt == 1) steps = abort_at;
    e.inst  = i;
    e.steps = steps;
    e.pos   = (e.dir == 0) ? ((cur_pos[i] - steps) & 255) : ((cur_pos[i] + steps) & 255);
    e.cyc   = (steps == 0) ? 1 : steps * (g + 1) - g + 1;
    for (int k = 0; k < 100 && ready_s[i] !== 1'b1; k++) @(negedge clk);
    @(posedge clk);
    #1;
    target_s[i] = tgt[7:0];
    start_s[i]  = 1'b1;
    @(posedge clk);
    e.t0 = cyc;
    sb.push_back(e);
    cur_pos[i] = e.pos;
    #1 start_s[i] = 1'b0;
    @(negedge clk);
    check_eq("busy_after_start", busy_s[i], (steps != 0) ? 1 : 0);
    check_eq("ready_after_start", ready_s[i], 0);
    if (e.abrt == 1) begin
      repeat (steps - 1) @(posedge clk);
      #1 abort_s[i] = 1'b1;
      @(posedge clk);
      #1 abort_s[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check_eq("move_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input int i);
    check_eq("rst_ready", ready_s[i], 1);
    check_eq("rst_busy", busy_s[i], 0);
    check_eq("rst_done", done_s[i], 0);
    check_eq("rst_aborted", aborted_s[i], 0);
    check_eq("rst_enable", enable_s[i], 0);
    check_eq("rst_direction", direction_s[i], 1);
    check_eq("rst_position", pos_s[i], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_s[i]   = 1'b0;
      abort_s[i]   = 1'b0;
      target_s[i]  = 8'd0;
      cur_pos[i]   = 0;
      en_cnt[i]    = 0;
      dir_err[i]   = 0;
      post_done[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) check_reset_values(i);

    move(0, 5, 0);    wait_idle(50);
    move(0, 250, 0);  wait_idle(50);
    move(0, 250, 0);  wait_idle(50);
    move(0, 0, 0);    wait_idle(50);
    move(0, 128, 0);  wait_idle(400);
    for (int r = 0; r < 6; r++) begin
      move(0, int'($urandom_range(0, 255)), 0);
      wait_idle(400);
    end

    // Slow instance: start requests while busy must be ignored.
    move(1, 3, 0);
    for (int p = 0; p < 2; p++) begin
      @(posedge clk);
      #1 start_s[1] = 1'b1;
      target_s[1] = 8'd99;
      @(posedge clk);
      #1 start_s[1] = 1'b0;
    end
    wait_idle(50);
    move(1, 0, 0);    wait_idle(50);

    move(0, 0, 0);    wait_idle(400);
    move(0, 10, 3);   wait_idle(50);

    // abort while idle does nothing
    @(posedge clk);
    #1 abort_s[0] = 1'b1;
    @(posedge clk);
    #1 abort_s[0] = 1'b0;
    @(negedge clk);
    check_eq("idle_abort_ready", ready_s[0], 1);
    check_eq("idle_abort_done", done_s[0], 0);

    // reset in the middle of a move abandons it without a done pulse
    move(0, 100, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) cur_pos[i] = 0;
    @(negedge clk);
    check_reset_values(0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
